// File: rtl/button_conditioner.sv
// button_conditioner
// -------------------
// Front-end for the seven sudoku board buttons. Each channel synchronises its
// raw pin, debounces it, and turns an accepted press into a registered
// single-cycle pulse for sudoku_fsm. The debounced levels are also exported.
//
// Ports:
//   clk                     system clock
//   reset                   asynchronous, active-high; clears all state
//   *_raw                   raw asynchronous button pins (start,a,b,up,down,left,right)
//   *_button                registered one-cycle press pulses
//   btn_level[6:0]          debounced pressed levels {right,left,down,up,b,a,start}
//
// Optional feature macro: BTN_AUTOREPEAT_EN
//   When defined, the up/down/left/right channels emit extra pulses while held:
//   the first REPEAT_DELAY cycles after the press pulse, then every
//   REPEAT_RATE cycles until release. When undefined, no hold timers exist and
//   every channel gives exactly one pulse per accepted press.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter bit ACTIVE_LOW      = 1'b0,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_RATE     = 10000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_raw,
   input  logic       a_raw,
   input  logic       b_raw,
   input  logic       up_raw,
   input  logic       down_raw,
   input  logic       left_raw,
   input  logic       right_raw,
   output logic       start_button,
   output logic       a_button,
   output logic       b_button,
   output logic       up_button,
   output logic       down_button,
   output logic       left_button,
   output logic       right_button,
   output logic [6:0] btn_level
);

   localparam int NB = 7;
   // Index of the first direction channel; only directions may auto-repeat.
   localparam int FIRST_DIR = 3;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
   localparam int REP_MAXV = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W    = $clog2(REP_MAXV) + 1;
   localparam logic [REP_W-1:0] DELAY_MAX = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] RATE_MAX  = REP_W'(REPEAT_RATE - 1);
`else
   // Repeat timing has no effect in this build; fold it into a dead net.
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

   logic [NB-1:0] raw_vec;
   logic [NB-1:0] pressed;
   logic [NB-1:0] s1_p0;
   logic [NB-1:0] s2_p1;
   logic [NB-1:0] stable_p2;
   logic [NB-1:0] press_p3;

   assign raw_vec = {right_raw, left_raw, down_raw, up_raw, b_raw, a_raw, start_raw};
   assign pressed = raw_vec ^ {NB{ACTIVE_LOW}};

   // ---- stage p0/p1: two-flop synchroniser ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_p0 <= '0;
         s2_p1 <= '0;
      end else begin
         s1_p0 <= pressed;
         s2_p1 <= s1_p0;
      end
   end

   for (genvar i = 0; i < NB; i++) begin : g_chan
      logic [CNT_W-1:0] cnt;
      logic             stable;
      logic             stable_d;
      logic             rise;
      logic             fire;
      logic             press;

      // ---- stage p2: debounce, stable accepted after DEBOUNCE_CYCLES ----
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
         end else if (s2_p1[i] == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            stable <= s2_p1[i];
            cnt    <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end

      // stable_d lags stable by one cycle, so rise is true for exactly the
      // cycle following a 0->1 acceptance.
      assign rise = stable & ~stable_d;

`ifdef BTN_AUTOREPEAT_EN
      if (i >= FIRST_DIR) begin : g_rep
         logic [REP_W-1:0] timer;
         logic             rep_active;
         logic             rep_hit;

         // First repeat waits REPEAT_DELAY after the press pulse; once
         // repeating, the interval drops to REPEAT_RATE.
         assign rep_hit = stable && (timer == (rep_active ? RATE_MAX : DELAY_MAX));
         assign fire    = rise | rep_hit;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               timer      <= '0;
               rep_active <= 1'b0;
            end else if (!stable) begin
               timer      <= '0;
               rep_active <= 1'b0;
            end else if (fire) begin
               timer      <= '0;
               rep_active <= rep_active | (rep_hit & ~rise);
            end else begin
               timer <= timer + REP_W'(1);
            end
         end
      end else begin : g_norep
         assign fire = rise;
      end
`else
      assign fire = rise;
`endif

      // ---- stage p3: registered press pulse ----
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            stable_d <= 1'b0;
            press    <= 1'b0;
         end else begin
            stable_d <= stable;
            press    <= fire;
         end
      end

      assign stable_p2[i] = stable;
      assign press_p3[i]  = press;
   end

   assign btn_level    = stable_p2;
   assign start_button = press_p3[0];
   assign a_button     = press_p3[1];
   assign b_button     = press_p3[2];
   assign up_button    = press_p3[3];
   assign down_button  = press_p3[4];
   assign left_button  = press_p3[5];
   assign right_button = press_p3[6];

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: an active-high instance and an active-low
// instance (driven with inverted pins) are compared every cycle against a
// timestamp-based behavioural model, plus directed latency/count checks.
module tb_button_conditioner;

   localparam int D  = 4;
   localparam int CW = 3;
   localparam int RD = 20;
   localparam int RR = 8;
`ifdef BTN_AUTOREPEAT_EN
   localparam int RIGHT_HOLD_EXP = 6;
   localparam bit REP_ON = 1'b1;
`else
   localparam int RIGHT_HOLD_EXP = 1;
   localparam bit REP_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] raw = '0;
   logic [6:0] raw_n;
   assign raw_n = ~raw;

   logic start_button, a_button, b_button, up_button, down_button, left_button, right_button;
   logic [6:0] btn_level;
   logic start_al, a_al, b_al, up_al, down_al, left_al, right_al;
   logic [6:0] btn_level_al;
   logic [6:0] press_v, press_al;
   assign press_v  = {right_button, left_button, down_button, up_button, b_button, a_button, start_button};
   assign press_al = {right_al, left_al, down_al, up_al, b_al, a_al, start_al};

   button_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(CW), .ACTIVE_LOW(1'b0),
                        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
      .clk(clk), .reset(reset),
      .start_raw(raw[0]), .a_raw(raw[1]), .b_raw(raw[2]), .up_raw(raw[3]),
      .down_raw(raw[4]), .left_raw(raw[5]), .right_raw(raw[6]),
      .start_button(start_button), .a_button(a_button), .b_button(b_button),
      .up_button(up_button), .down_button(down_button), .left_button(left_button),
      .right_button(right_button), .btn_level(btn_level));

   button_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(CW), .ACTIVE_LOW(1'b1),
                        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_al (
      .clk(clk), .reset(reset),
      .start_raw(raw_n[0]), .a_raw(raw_n[1]), .b_raw(raw_n[2]), .up_raw(raw_n[3]),
      .down_raw(raw_n[4]), .left_raw(raw_n[5]), .right_raw(raw_n[6]),
      .start_button(start_al), .a_button(a_al), .b_button(b_al),
      .up_button(up_al), .down_button(down_al), .left_button(left_al),
      .right_button(right_al), .btn_level(btn_level_al));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---- behavioural model: timestamps instead of counters ----
   int         edge_n = 0;
   logic [6:0] dly[$] = '{7'b0, 7'b0};   // two-cycle synchroniser delay line
   int         last_agree[7];            // last edge where s2 matched the level
   int         t0[7];                    // edge of the most recent press pulse
   logic [6:0] m_lvl = '0;
   logic [6:0] m_rose_last = '0;
   logic [6:0] m_press = '0;

   // observed bookkeeping for directed checks
   int         obs_cnt[7];
   int         first_pulse[7];
   int         lvl_rise[7];
   int         lvl_fall[7];
   logic [6:0] prev_lvl = '0;

   task automatic arm();
      for (int b = 0; b < 7; b++) begin
         obs_cnt[b] = 0; first_pulse[b] = -1; lvl_rise[b] = -1; lvl_fall[b] = -1;
      end
   endtask

   always @(posedge clk) begin
      logic [6:0] s2v, lvl_old;
      edge_n++;
      if (reset) begin
         dly = '{7'b0, 7'b0};
         m_lvl = '0; m_rose_last = '0; m_press = '0;
         for (int b = 0; b < 7; b++) begin last_agree[b] = edge_n; t0[b] = edge_n; end
      end else begin
         dly.push_back(raw);
         s2v = dly.pop_front();
         lvl_old = m_lvl;
         m_press = m_rose_last;
         for (int b = 0; b < 7; b++) begin
            if (m_rose_last[b]) t0[b] = edge_n;
            else if (REP_ON && b >= 3 && lvl_old[b] && (edge_n - t0[b]) >= RD &&
                     ((edge_n - t0[b] - RD) % RR) == 0)
               m_press[b] = 1'b1;
            if (s2v[b] == m_lvl[b]) last_agree[b] = edge_n;
            else if (edge_n - last_agree[b] == D) begin
               m_lvl[b] = s2v[b];
               last_agree[b] = edge_n;
            end
         end
         m_rose_last = m_lvl & ~lvl_old;
      end
      #1;
      check("press", 32'(press_v), 32'(m_press));
      check("level", 32'(btn_level), 32'(m_lvl));
      check("press_al", 32'(press_al), 32'(m_press));
      check("level_al", 32'(btn_level_al), 32'(m_lvl));
      for (int b = 0; b < 7; b++) begin
         if (press_v[b]) begin
            obs_cnt[b]++;
            if (first_pulse[b] < 0) first_pulse[b] = edge_n;
         end
         if (btn_level[b] && !prev_lvl[b] && lvl_rise[b] < 0) lvl_rise[b] = edge_n;
         if (!btn_level[b] && prev_lvl[b] && lvl_fall[b] < 0) lvl_fall[b] = edge_n;
      end
      prev_lvl = btn_level;
   end

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   initial begin
      int e;
      arm();
      cyc(3);
      check("reset_level", 32'(btn_level), 32'd0);
      check("reset_press", 32'(press_v), 32'd0);
      reset = 1'b0;
      cyc(10);

      // held start: one pulse at E+D+2, level from E+D+1
      arm();
      raw[0] = 1'b1; e = edge_n + 1;
      cyc(100);
      check("start_pulse_edge", 32'(first_pulse[0]), 32'(e + D + 2));
      check("start_level_edge", 32'(lvl_rise[0]), 32'(e + D + 1));
      check("start_count", 32'(obs_cnt[0]), 32'd1);
      raw[0] = 1'b0; cyc(12);

      // short glitch on up: rejected
      arm();
      raw[3] = 1'b1; cyc(3); raw[3] = 1'b0; cyc(15);
      check("up_glitch_count", 32'(obs_cnt[3]), 32'd0);
      check("up_glitch_level", 32'(lvl_rise[3]), 32'hFFFF_FFFF);

      // bouncing a then held: one pulse 6 edges after final rise
      arm();
      raw[1] = 1'b1; cyc(1); raw[1] = 1'b0; cyc(1);
      raw[1] = 1'b1; cyc(1); raw[1] = 1'b0; cyc(1);
      raw[1] = 1'b1; e = edge_n + 1; cyc(40);
      check("a_bounce_edge", 32'(first_pulse[1]), 32'(e + 6));
      check("a_bounce_count", 32'(obs_cnt[1]), 32'd1);
      raw[1] = 1'b0; cyc(12);

      // down press/release: level falls 5 edges after release sample
      arm();
      raw[4] = 1'b1; cyc(20);
      raw[4] = 1'b0; e = edge_n + 1; cyc(20);
      check("down_count", 32'(obs_cnt[4]), 32'd1);
      check("down_fall_edge", 32'(lvl_fall[4]), 32'(e + 5));

      // left held through reset, b aborted by reset mid-debounce
      arm();
      raw[5] = 1'b1; raw[2] = 1'b1; cyc(3);
      reset = 1'b1; cyc(2);
      check("reset_mid_level", 32'(btn_level), 32'd0);
      raw[2] = 1'b0; cyc(2);
      arm();
      reset = 1'b0; e = edge_n + 1; cyc(30);
      check("left_after_reset_edge", 32'(first_pulse[5]), 32'(e + 6));
      check("left_after_reset_count", 32'(obs_cnt[5]), 32'd1);
      check("b_aborted_count", 32'(obs_cnt[2]), 32'd0);
      raw[5] = 1'b0; cyc(12);

      // long hold on right and start: repeats only on the direction
      arm();
      raw[6] = 1'b1; raw[0] = 1'b1; cyc(60);
      raw[6] = 1'b0; raw[0] = 1'b0; cyc(30);
      check("right_hold_count", 32'(obs_cnt[6]), 32'(RIGHT_HOLD_EXP));
      check("start_hold_count", 32'(obs_cnt[0]), 32'd1);

      // randomized bouncing with occasional resets, checked by the model
      for (int chunk = 0; chunk < 60; chunk++) begin
         int rate = ($urandom_range(0, 1) == 0) ? 3 : 25;
         for (int c = 0; c < 50; c++) begin
            for (int b = 0; b < 7; b++)
               if ($urandom_range(0, rate - 1) == 0) raw[b] = ~raw[b];
            reset = ($urandom_range(0, 299) == 0);
            cyc(1);
         end
      end
      reset = 1'b0;
      raw = '0;
      cyc(40);
      check("final_idle_level", 32'(btn_level), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
